// File: rtl/hazard_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer_pkg
// Description : Shared pipeline definitions for the hazard sequencer: the
//               sequencer state encoding and the default width of the
//               saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_sequencer_pkg;

    // Encoding 2'd3 is deliberately left unused; the sequencer recovers
    // from it to RUN on the next edge.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HAZARD  = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage : hazard_sequencer_pkg
`default_nettype wire

// File: rtl/hazard_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments by one on each enabled edge and
//               sticks at all-ones instead of wrapping.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - increment request for this edge
//               cnt   - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Pipeline stall/flush sequencer. Arbitrates cache-miss,
//               data-hazard and redirect requests (mem > haz > redirect)
//               into per-stage write enables, bubble and flush controls,
//               and counts stall and flush cycles.
// Ports       : clk, rst_n            - clock, async active-low reset
//               stall_lu, stall_j     - data-hazard requests
//               icache_stall,
//               dcache_stall          - cache miss in progress
//               redirect              - control-flow change resolved in ID
//               pc_we .. memwb_we     - pipeline write enables
//               ifid_flush            - IF/ID load NOP
//               idex_bubble           - ID/EX load NOP
//               state                 - current sequencer state
//               stall_cnt, flush_cnt  - saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_lu,
    input  logic             stall_j,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             redirect,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t r_state;
    state_t w_next;
    logic   r_pend;
    logic   w_mem;
    logic   w_haz;

    assign w_mem = icache_stall | dcache_stall;
    assign w_haz = stall_lu | stall_j;

    // Control outputs are combinational so a stall takes effect in the same
    // cycle it is requested.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        w_next      = ST_RUN;
        if (w_mem) begin
            // Whole pipeline frozen; nothing moves so no bubble or flush.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
            w_next   = ST_MEMWAIT;
        end else if (w_haz) begin
            // Front end holds, a bubble is injected into EX.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            w_next      = ST_HAZARD;
        end else begin
            // A redirect swallowed during a stall is replayed here.
            ifid_flush = redirect | r_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_HAZARD, ST_MEMWAIT: r_state <= w_next;
                default:                       r_state <= ST_RUN;
            endcase
            // Pend remembers a redirect seen while stalled and is released in
            // the first unstalled cycle, which is the cycle that flushes.
            if (w_mem || w_haz) begin
                r_pend <= r_pend | redirect;
            end else begin
                r_pend <= 1'b0;
            end
        end
    end

    assign state = r_state;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_we),
        .cnt   (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .cnt   (flush_cnt)
    );

endmodule : hazard_sequencer
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sequencer
// Description : Self-checking bench for hazard_sequencer. A 16-bit and a
//               4-bit counter instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

    typedef struct {
        logic       lu;
        logic       j;
        logic       ic;
        logic       dc;
        logic       rd;
        logic [6:0] ctl;   // {pc_we,ifid_we,ifid_flush,idex_we,idex_bubble,exmem_we,memwb_we}
        logic [1:0] st;    // state expected after the edge
    } vec_t;

    localparam logic [6:0] C_IDLE  = 7'b1101011;
    localparam logic [6:0] C_FLUSH = 7'b1111011;
    localparam logic [6:0] C_HAZ   = 7'b0001111;
    localparam logic [6:0] C_MEM   = 7'b0000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_lu = 1'b0, stall_j = 1'b0, icache_stall = 1'b0;
    logic dcache_stall = 1'b0, redirect = 1'b0;

    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_we4, idex_bubble4, exmem_we4, memwb_we4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int errors = 0;
    int checks = 0;
    int m_stall, m_flush, m_stall4;
    vec_t sb[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    hazard_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_lu(stall_lu), .stall_j(stall_j),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .redirect(redirect),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_lu(stall_lu), .stall_j(stall_j),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .redirect(redirect),
        .pc_we(pc_we4), .ifid_we(ifid_we4), .ifid_flush(ifid_flush4), .idex_we(idex_we4),
        .idex_bubble(idex_bubble4), .exmem_we(exmem_we4), .memwb_we(memwb_we4),
        .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic lu, input logic j, input logic ic, input logic dc,
                                input logic rd, input logic [6:0] ctl, input logic [1:0] st);
        vec_t v;
        v.lu = lu; v.j = j; v.ic = ic; v.dc = dc; v.rd = rd; v.ctl = ctl; v.st = st;
        return v;
    endfunction

    // One cycle, entered and left at a falling edge.
    task automatic cycle(input string name, input vec_t v);
        vec_t e;
        stall_lu = v.lu; stall_j = v.j; icache_stall = v.ic; dcache_stall = v.dc; redirect = v.rd;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        check({name, ".ctl"}, {25'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
                               exmem_we, memwb_we}, {25'd0, e.ctl});
        @(posedge clk);
        #1;
        if (e.ctl[6] == 1'b0) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall4 < 15) m_stall4++;
        end
        if (e.ctl[4] == 1'b1 && m_flush < 65535) m_flush++;
        check({name, ".state"}, {30'd0, state}, {30'd0, e.st});
        check({name, ".stall_cnt"}, {16'd0, stall_cnt}, m_stall);
        check({name, ".flush_cnt"}, {16'd0, flush_cnt}, m_flush);
        check({name, ".stall_cnt4"}, {28'd0, stall_cnt4}, m_stall4);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_lu = 0; stall_j = 0; icache_stall = 0; dcache_stall = 0; redirect = 0;
        @(posedge clk);
        #1;
        check("rst.state", {30'd0, state}, 32'd0);
        check("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_stall = 0; m_flush = 0; m_stall4 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 0, C_IDLE,  2'd0);
        tbl[1] = mk(0, 0, 0, 0, 1, C_FLUSH, 2'd0);
        tbl[2] = mk(1, 0, 0, 0, 0, C_HAZ,   2'd1);
        tbl[3] = mk(0, 1, 0, 0, 0, C_HAZ,   2'd1);
        tbl[4] = mk(0, 0, 1, 0, 0, C_MEM,   2'd2);
        tbl[5] = mk(0, 0, 0, 1, 0, C_MEM,   2'd2);
        tbl[6] = mk(1, 0, 1, 0, 0, C_MEM,   2'd2);
        tbl[7] = mk(1, 1, 0, 0, 0, C_HAZ,   2'd1);

        // Reset then idle for three cycles
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) cycle("idle", tbl[0]);

        // Table of single-cycle patterns (none leaves a pending redirect)
        for (int i = 0; i < 8; i++) cycle($sformatf("tbl%0d", i), tbl[i]);
        cycle("tbl_end", tbl[0]);

        // Single load-use stall, then back to RUN
        do_reset();
        cycle("lu1", tbl[2]);
        cycle("lu1_after", tbl[0]);

        // Five-cycle dcache miss with a redirect in the second cycle
        do_reset();
        cycle("dmiss1", mk(0, 0, 0, 1, 0, C_MEM, 2'd2));
        cycle("dmiss2", mk(0, 0, 0, 1, 1, C_MEM, 2'd2));
        for (int i = 0; i < 3; i++) cycle("dmiss", mk(0, 0, 0, 1, 0, C_MEM, 2'd2));
        cycle("dmiss_flush", mk(0, 0, 0, 0, 0, C_FLUSH, 2'd0));
        cycle("dmiss_noflush", tbl[0]);
        check("dmiss.stall_total", {16'd0, stall_cnt}, 32'd5);
        check("dmiss.flush_total", {16'd0, flush_cnt}, 32'd1);

        // Redirect arriving as a hazard drops: one flush only
        do_reset();
        cycle("drop_haz", mk(1, 0, 0, 0, 1, C_HAZ, 2'd1));
        cycle("drop_flush", mk(0, 0, 0, 0, 1, C_FLUSH, 2'd0));
        cycle("drop_after", tbl[0]);

        // icache + jump hazard together, then jump hazard alone
        do_reset();
        for (int i = 0; i < 2; i++) cycle("ic_j", mk(0, 1, 1, 0, 0, C_MEM, 2'd2));
        cycle("j_alone", mk(0, 1, 0, 0, 0, C_HAZ, 2'd1));
        cycle("j_done", tbl[0]);

        // Saturation of the 4-bit counter over 20 stall cycles
        do_reset();
        for (int i = 0; i < 20; i++) cycle("sat", tbl[2]);
        cycle("sat_idle", tbl[0]);
        check("sat.cnt4", {28'd0, stall_cnt4}, 32'd15);
        check("sat.cnt16", {16'd0, stall_cnt}, 32'd20);

        // Reset pulsed during MEMWAIT with a pending redirect
        do_reset();
        cycle("rmw1", mk(0, 0, 0, 1, 1, C_MEM, 2'd2));
        cycle("rmw2", mk(0, 0, 0, 1, 0, C_MEM, 2'd2));
        rst_n = 1'b0;
        dcache_stall = 1'b0;
        #1;
        check("rmw.async_state", {30'd0, state}, 32'd0);
        check("rmw.async_stall", {16'd0, stall_cnt}, 32'd0);
        check("rmw.async_flush", {16'd0, flush_cnt}, 32'd0);
        check("rmw.async_ifid_flush", {31'd0, ifid_flush}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_stall = 0; m_flush = 0; m_stall4 = 0;
        cycle("rmw_release", tbl[0]);
        cycle("rmw_release2", tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_sequencer
`default_nettype wire
